// File: rtl/instruction_loader.sv
// Byte-stream program loader: parses a length-prefixed frame and writes 28-bit words into instruction RAM.
// Optional trailing checksum byte enabled with `define LOADER_CHECKSUM_EN.
module instruction_loader #(
    parameter logic [15:0] BASE_ADDRESS = 16'd0,
    parameter int          MAX_WORDS    = 256
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iStart,
    input  logic [7:0]  iByte,
    input  logic        iByteValid,
    output logic        oByteReady,
    output logic        oWriteEnable,
    output logic [15:0] oWriteAddress,
    output logic [27:0] oWriteInstruction,
    output logic        oCpuHold,
    output logic        oDone,
    output logic        oError
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
`ifdef LOADER_CHECKSUM_EN
        S_ERROR  = 3'd6,
        S_CHECK  = 3'd7
`else
        S_ERROR  = 3'd6
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [19:0] asm_q, asm_d;
    logic [15:0] addr_q, addr_d;
    logic [27:0] instr_q, instr_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    logic        byte_ready;
    logic        accept;
    logic [15:0] len_full;
    logic [15:0] idx_next;

    assign accept   = iByteValid && byte_ready;
    assign len_full = {len_q[15:8], iByte};
    assign idx_next = idx_q + 16'd1;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            addr_q  <= '0;
            instr_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        addr_d  = addr_q;
        instr_d = instr_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (iStart) begin
                    state_d = S_LEN_HI;
                    len_d   = '0;
                    idx_d   = '0;
                    bidx_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = iByte;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d  = len_full;
                    idx_d  = '0;
                    bidx_d = '0;
                    if ({1'b0, len_full} > MAX_W) begin
                        state_d = S_ERROR;
                    end else if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + iByte;
`endif
                    bidx_d = bidx_q + 2'd1;
                    case (bidx_q)
                        2'd0: begin
                            // Only 28 bits fit: a nonzero top nibble means a corrupt stream.
                            if (iByte[7:4] != 4'd0) state_d = S_ERROR;
                            else                    asm_d   = {16'd0, iByte[3:0]};
                        end
                        2'd3: begin
                            instr_d = {asm_q, iByte};
                            addr_d  = BASE_ADDRESS + idx_q;
                            state_d = S_WRITE;
                        end
                        default: asm_d = {asm_q[11:0], iByte};
                    endcase
                end
            end
            S_WRITE: begin
                idx_d  = idx_next;
                bidx_d = '0;
                if (idx_next == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) state_d = (iByte == sum_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready   = 1'b0;
        oWriteEnable = 1'b0;
        oCpuHold     = 1'b1;
        oDone        = 1'b0;
        oError       = 1'b0;
        case (state_q)
            S_IDLE:                     oCpuHold   = 1'b0;
            S_LEN_HI, S_LEN_LO, S_DATA: byte_ready = 1'b1;
            S_WRITE:                    oWriteEnable = 1'b1;
            S_DONE: begin
                oCpuHold = 1'b0;
                oDone    = 1'b1;
            end
            S_ERROR:                    oError = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK:                    byte_ready = 1'b1;
`endif
            default: ;
        endcase
    end

    assign oByteReady        = byte_ready;
    assign oWriteAddress     = addr_q;
    assign oWriteInstruction = instr_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: frame table plus reset, latency and throttled-valid sequences.
module tb_instruction_loader;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStart;
    logic [7:0]  iByte;
    logic        iByteValid;
    logic        oByteReady;
    logic        oWriteEnable;
    logic [15:0] oWriteAddress;
    logic [27:0] oWriteInstruction;
    logic        oCpuHold;
    logic        oDone;
    logic        oError;

    instruction_loader dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .iStart            (iStart),
        .iByte             (iByte),
        .iByteValid        (iByteValid),
        .oByteReady        (oByteReady),
        .oWriteEnable      (oWriteEnable),
        .oWriteAddress     (oWriteAddress),
        .oWriteInstruction (oWriteInstruction),
        .oCpuHold          (oCpuHold),
        .oDone             (oDone),
        .oError            (oError)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [95:0] stream;
        int          nbytes;
        logic [55:0] wr;
        int          nwr;
        logic        done;
        logic        err;
    } vec_t;

    vec_t        vt[8];
    int          nvec;
    int          n_vec = 0;
    int          n_mis = 0;
    logic [15:0] wa[$];
    logic [27:0] wd[$];
    logic        chk_rdy = 1'b0;
    int          viol = 0;

    always @(negedge Clock) begin
        if (oWriteEnable === 1'b1) begin
            wa.push_back(oWriteAddress);
            wd.push_back(oWriteInstruction);
        end
        if (chk_rdy && oCpuHold && !oError && (oByteReady == oWriteEnable)) viol++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic start();
        @(negedge Clock);
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
    endtask

    // Present one byte and return on the falling edge after it is consumed.
    task automatic send(input logic [7:0] b);
        int t = 0;
        iByte      = b;
        iByteValid = 1'b1;
        while (!oByteReady && t < 50) begin
            @(negedge Clock);
            t++;
        end
        if (!oByteReady) begin
            n_vec++;
            n_mis++;
            $display("FAIL send timeout: got ready=%b, want 1", oByteReady);
        end else begin
            @(posedge Clock);
            @(negedge Clock);
        end
    endtask

    task automatic wait_end(input string nm);
        int t = 0;
        while (!(oDone || oError) && t < 10) begin
            @(negedge Clock);
            t++;
        end
        chk({nm, " finish"}, 32'(oDone || oError), 32'd1);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " ready"}, 32'(oByteReady), 32'd0);
        chk({nm, " we"},    32'(oWriteEnable), 32'd0);
        chk({nm, " addr"},  32'(oWriteAddress), 32'd0);
        chk({nm, " instr"}, 32'(oWriteInstruction), 32'd0);
        chk({nm, " hold"},  32'(oCpuHold), 32'd0);
        chk({nm, " done"},  32'(oDone), 32'd0);
        chk({nm, " err"},   32'(oError), 32'd0);
    endtask

    initial begin
        logic [7:0] fr[12];

`ifdef LOADER_CHECKSUM_EN
        vt[0] = '{96'h000200D0000203A0000F84, 11, {28'h0D00002, 28'h3A0000F}, 2, 1'b1, 1'b0};
        vt[1] = '{96'h0101,                    2,  56'h0,                      0, 1'b0, 1'b1};
        vt[2] = '{96'h00010012345_69C,         7,  56'h0123456,                1, 1'b1, 1'b0};
        vt[3] = '{96'h00011F,                  3,  56'h0,                      0, 1'b0, 1'b1};
        vt[4] = '{96'h000000,                  3,  56'h0,                      0, 1'b1, 1'b0};
        vt[5] = '{96'h0001010203040A,          7,  56'h1020304,                1, 1'b1, 1'b0};
        vt[6] = '{96'h0001010203040B,          7,  56'h1020304,                1, 1'b0, 1'b1};
        nvec  = 7;
`else
        vt[0] = '{96'h000200D0000203A0000F,    10, {28'h0D00002, 28'h3A0000F}, 2, 1'b1, 1'b0};
        vt[1] = '{96'h0101,                    2,  56'h0,                      0, 1'b0, 1'b1};
        vt[2] = '{96'h000100123456,            6,  56'h0123456,                1, 1'b1, 1'b0};
        vt[3] = '{96'h00011F,                  3,  56'h0,                      0, 1'b0, 1'b1};
        vt[4] = '{96'h0000,                    2,  56'h0,                      0, 1'b1, 1'b0};
        nvec  = 5;
`endif

        Reset      = 1'b0;
        iStart     = 1'b0;
        iByte      = 8'h00;
        iByteValid = 1'b0;
        repeat (3) @(negedge Clock);
        chk_idle_outputs("reset");
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        chk("idle hold", 32'(oCpuHold), 32'd0);

        for (int i = 0; i < nvec; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            wa.delete();
            wd.delete();
            start();
            for (int j = 0; j < vt[i].nbytes; j++)
                send(vt[i].stream[8*(vt[i].nbytes-1-j) +: 8]);
            iByteValid = 1'b0;
            wait_end(nm);
            chk({nm, " done"},  32'(oDone), 32'(vt[i].done));
            chk({nm, " err"},   32'(oError), 32'(vt[i].err));
            chk({nm, " hold"},  32'(oCpuHold), 32'(vt[i].err));
            chk({nm, " ready"}, 32'(oByteReady), 32'd0);
            chk({nm, " nwr"},   32'(wa.size()), 32'(vt[i].nwr));
            for (int k = 0; k < vt[i].nwr && k < wa.size(); k++) begin
                chk($sformatf("%s addr%0d", nm, k), 32'(wa[k]), 32'(k));
                chk($sformatf("%s data%0d", nm, k), 32'(wd[k]),
                    32'(vt[i].wr[28*(vt[i].nwr-1-k) +: 28]));
            end
        end

        // Throttled valid with latency checks around the final write.
        fr = '{8'h00, 8'h02, 8'h00, 8'hD0, 8'h00, 8'h02, 8'h03, 8'hA0, 8'h00, 8'h0F, 8'h00, 8'h00};
        wa.delete();
        wd.delete();
        viol = 0;
        start();
        chk_rdy = 1'b1;
        for (int j = 0; j < 10; j++) begin
            send(fr[j]);
            if (j < 9) begin
                iByteValid = 1'b0;
                @(negedge Clock);
            end
        end
        iByteValid = 1'b0;
        chk("tog last we",    32'(oWriteEnable), 32'd1);
        chk("tog last addr",  32'(oWriteAddress), 32'd1);
        chk("tog last instr", 32'(oWriteInstruction), 32'h3A0000F);
`ifdef LOADER_CHECKSUM_EN
        send(8'h84);
        iByteValid = 1'b0;
`else
        @(negedge Clock);
`endif
        chk("tog done", 32'(oDone), 32'd1);
        chk("tog hold", 32'(oCpuHold), 32'd0);
        chk("tog we",   32'(oWriteEnable), 32'd0);
        chk_rdy = 1'b0;
        chk("tog ready only low in write", 32'(viol), 32'd0);
        chk("tog nwr", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("tog data0", 32'(wd[0]), 32'h0D00002);
            chk("tog data1", 32'(wd[1]), 32'h3A0000F);
            chk("tog addr0", 32'(wa[0]), 32'd0);
        end

        // Reset in the middle of DATA after two payload bytes.
        wa.delete();
        wd.delete();
        start();
        send(8'h00);
        send(8'h01);
        send(8'h00);
        send(8'h12);
        iByteValid = 1'b0;
        chk("mid hold before reset", 32'(oCpuHold), 32'd1);
        Reset = 1'b0;
        #1;
        chk_idle_outputs("mid reset");
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        repeat (6) @(negedge Clock);
        chk_idle_outputs("after reset");
        chk("after reset nwr", 32'(wa.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
